// File: rtl/dsp_simd_alu.sv
// Pipelined SIMD ALU: per-lane add/sub/logic/mul plus per-lane wrapping accumulators.
// Results appear `latency` cycles after the beat is accepted. A refused output beat stalls every stage.
module dsp_simd_alu #(
  parameter int width   = 12,
  parameter int lanes   = 4,
  parameter int latency = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             op,
  input  logic [lanes*width-1:0] a,
  input  logic [lanes*width-1:0] b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [lanes*width-1:0] y
);

  typedef logic [lanes-1:0][width-1:0] vec_t;

  vec_t                                a_l;
  vec_t                                b_l;
  vec_t                                res_d;
  vec_t                                acc_q;
  vec_t                                acc_d;
  logic [latency-1:0]                  vld_q;
  logic [latency-1:0][lanes*width-1:0] dat_q;

  assign a_l       = a;
  assign b_l       = b;
  assign in_ready  = out_ready || !out_valid;
  assign out_valid = vld_q[latency-1];
  assign y         = dat_q[latency-1];

  function automatic logic [width-1:0] lane_op(input logic [3:0]       f,
                                               input logic [width-1:0] x,
                                               input logic [width-1:0] z);
    case (f)
      4'd0:    lane_op = x + z;
      4'd1:    lane_op = x - z;
      4'd2:    lane_op = x & z;
      4'd3:    lane_op = x | z;
      4'd4:    lane_op = x ^ z;
      4'd5:    lane_op = ~(x | z);
      4'd6:    lane_op = ~(x ^ z);
      4'd7:    lane_op = x * z;
      default: lane_op = '0;
    endcase
  endfunction

  // Lane arithmetic is done at lane width, so carries and borrows never cross lanes.
  always_comb begin
    acc_d = acc_q;
    res_d = '0;
    for (int i = 0; i < lanes; i++) begin
      case (op)
        4'd8: begin
          acc_d[i] = acc_q[i] + a_l[i];
          res_d[i] = acc_q[i] + a_l[i];
        end
        4'd9: begin
          acc_d[i] = '0;
          res_d[i] = '0;
        end
        default: res_d[i] = lane_op(op, a_l[i], b_l[i]);
      endcase
    end
  end

  // Data registers load only behind a valid beat so y holds its last result across bubbles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      dat_q <= '0;
      acc_q <= '0;
    end else if (in_ready) begin
      vld_q[0] <= in_valid;
      if (in_valid) begin
        dat_q[0] <= res_d;
        acc_q    <= acc_d;
      end
      for (int s = 1; s < latency; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) dat_q[s] <= dat_q[s-1];
      end
    end
  end

endmodule

// File: tb/tb_dsp_simd_alu.sv
// Bench for dsp_simd_alu: directed steps from the test plan, then random traffic against a lane-arithmetic model.
module tb_dsp_simd_alu;

  localparam int WID   = 12;
  localparam int LANES = 4;
  localparam int LAT   = 2;
  localparam int W     = WID * LANES;

  logic         clock;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y;

  dsp_simd_alu #(.width(WID), .lanes(LANES), .latency(LAT)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int              nchk;
  int              npass;
  int              cnum;
  logic [W-1:0]    expq[$];
  logic [W-1:0]    got[$];
  int              gotc[$];
  longint unsigned macc[LANES];
  logic            ov_s;
  logic            ir_s;
  logic [W-1:0]    y_s;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
    nchk++;
    assert (obs === expv) npass++;
    else $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
  endtask

  // Reference: each lane treated as an unsigned number modulo 2^WID.
  task automatic model_accept(input logic [3:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
    logic [W-1:0]    r;
    longint unsigned m, x, z, v;
    r = '0;
    m = 64'd1 << WID;
    for (int l = 0; l < LANES; l++) begin
      x = 64'(aa[l*WID +: WID]);
      z = 64'(bb[l*WID +: WID]);
      case (o)
        4'd0: v = (x + z) % m;
        4'd1: v = (x + m - z) % m;
        4'd2: v = x & z;
        4'd3: v = x | z;
        4'd4: v = x ^ z;
        4'd5: v = (m - 1) - (x | z);
        4'd6: v = (m - 1) - (x ^ z);
        4'd7: v = (x * z) % m;
        4'd8: begin macc[l] = (macc[l] + x) % m; v = macc[l]; end
        4'd9: begin macc[l] = 0; v = 0; end
        default: v = 0;
      endcase
      r[l*WID +: WID] = v[WID-1:0];
    end
    expq.push_back(r);
  endtask

  // One clock cycle: drive just after a posedge, sample at the negedge, return just after the next posedge.
  task automatic cyc(input logic v, input logic [3:0] o, input logic [W-1:0] aa,
                     input logic [W-1:0] bb, input logic ordy);
    in_valid  = v;
    op        = o;
    a         = aa;
    b         = bb;
    out_ready = ordy;
    @(negedge clock);
    ov_s = out_valid;
    ir_s = in_ready;
    y_s  = y;
    if (ov_s && out_ready) begin
      check("out_expected", W'(expq.size() > 0), W'(1));
      if (expq.size() > 0) check("y_order", y_s, expq.pop_front());
      got.push_back(y_s);
      gotc.push_back(cnum);
    end
    if (in_valid && ir_s) model_accept(o, aa, bb);
    cnum++;
    @(posedge clock);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && expq.size() > 0; i++) cyc(1'b0, 4'd0, '0, '0, 1'b1);
    check("drain_empty", W'(expq.size()), W'(0));
  endtask

  function automatic logic [W-1:0] rep(input logic [WID-1:0] v);
    return {LANES{v}};
  endfunction

  initial begin
    logic [W-1:0] ta, tb_v, yhold;
    logic [W-1:0] beat_a[4];
    int           bi;
    nchk = 0; npass = 0; cnum = 0;
    for (int l = 0; l < LANES; l++) macc[l] = 0;
    reset = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;

    // Reset state
    @(posedge clock);
    #1;
    check("rst_out_valid", W'(out_valid), W'(0));
    check("rst_y", y, '0);
    check("rst_in_ready", W'(in_ready), W'(1));
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Add: latency and no inter-lane carry
    ta   = 48'hFEC0FF017FFF;
    tb_v = 48'hFF9007007010;
    cyc(1'b1, 4'd0, ta, tb_v, 1'b1);
    for (int i = 1; i < LAT; i++) begin
      cyc(1'b0, 4'd0, '0, '0, 1'b1);
      check("add_early_valid", W'(ov_s), W'(0));
    end
    cyc(1'b0, 4'd0, '0, '0, 1'b1);
    check("add_valid_at_latency", W'(ov_s), W'(1));
    check("add_y", y_s, 48'hFE510601E00F);

    // Sub
    got.delete();
    cyc(1'b1, 4'd1, ta, tb_v, 1'b1);
    drain();
    check("sub_y", got[0], 48'hFF30F8010FEF);

    // Mul then the logic ops, streamed back to back
    got.delete();
    cyc(1'b1, 4'd7, rep(12'hF01), rep(12'h003), 1'b1);
    for (int o = 2; o <= 6; o++) cyc(1'b1, 4'(o), rep(12'h00A), rep(12'h001), 1'b1);
    drain();
    check("mul_y", got[0], 48'hD03D03D03D03);
    check("and_y", got[1], rep(12'h000));
    check("or_y", got[2], rep(12'h00B));
    check("xor_y", got[3], rep(12'h00B));
    check("nor_y", got[4], rep(12'hFF4));
    check("xnor_y", got[5], rep(12'hFF4));

    // Accumulate with wrap-around, then an interleaved add must not disturb it
    got.delete(); gotc.delete();
    cyc(1'b1, 4'd9, '0, '0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 4'd8, rep(12'h800), $urandom, 1'b1);
    drain();
    check("acc_y0", got[0], rep(12'h000));
    check("acc_y1", got[1], rep(12'h800));
    check("acc_y2", got[2], rep(12'h000));
    check("acc_y3", got[3], rep(12'h800));
    check("acc_consecutive", W'(gotc[3] - gotc[0]), W'(3));
    got.delete();
    cyc(1'b1, 4'd0, rep(12'h001), rep(12'h001), 1'b1);
    cyc(1'b1, 4'd8, rep(12'h001), '0, 1'b1);
    drain();
    check("acc_undisturbed", got[1], rep(12'h801));

    // Backpressure: only LAT beats fit before the stall
    got.delete(); gotc.delete();
    for (int i = 0; i < 4; i++) beat_a[i] = rep(12'(i + 1) * 12'h111);
    bi = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 4'd0, beat_a[bi], rep(12'h005), 1'b0);
      if (ir_s) bi++;
      if (i == 2) yhold = y_s;
    end
    check("bp_accepted", W'(bi), W'(2));
    check("bp_in_ready", W'(ir_s), W'(0));
    check("bp_out_valid", W'(ov_s), W'(1));
    check("bp_y_stable", y_s, yhold);
    for (int i = 0; i < 10 && bi < 4; i++) begin
      cyc(1'b1, 4'd0, beat_a[bi], rep(12'h005), 1'b1);
      if (ir_s) bi++;
    end
    drain();
    check("bp_delivered", W'(got.size()), W'(4));
    check("bp_one_per_cycle", W'(gotc[got.size()-1] - gotc[0]), W'(3));
    check("bp_last", got[got.size()-1], rep(12'h444 + 12'h005));

    // Random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
          {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0));
    drain();

    // Reset mid-operation
    cyc(1'b1, 4'd9, '0, '0, 1'b1);
    cyc(1'b1, 4'd8, rep(12'h123), '0, 1'b1);
    cyc(1'b1, 4'd0, rep(12'h010), rep(12'h020), 1'b1);
    cyc(1'b1, 4'd1, rep(12'h030), rep(12'h001), 1'b1);
    check("pre_rst_in_flight", W'(expq.size()), W'(2));
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check("midrst_out_valid", W'(out_valid), W'(0));
    check("midrst_y", y, '0);
    check("midrst_in_ready", W'(in_ready), W'(1));
    expq.delete();
    for (int l = 0; l < LANES; l++) macc[l] = 0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 4'd0, '0, '0, 1'b1);
      check("postrst_no_stale", W'(ov_s), W'(0));
    end
    got.delete();
    cyc(1'b1, 4'd8, rep(12'h001), '0, 1'b1);
    drain();
    check("postrst_acc", got[0], rep(12'h001));

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
